jstk2_spi_responder: RTL and testbench

//  SPI mode-0 target that emulates a Digilent JSTK2 joystick module on a PMOD. It answers the

---
 rtl/jstk2_pkg.sv | 26 ++
 rtl/jstk2_spi_responder_sync.sv | 30 +++
 rtl/jstk2_spi_responder.sv | 145 ++++++++++++++
 tb/tb_jstk2_spi_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/jstk2_pkg.sv
// jstk2_pkg: shared constants, state encoding and TX frame packing for the JSTK2 responder.
package jstk2_pkg;

    localparam logic [7:0] JSTK2_CMD_SET_LED = 8'h84;

    localparam int XL  = 0;
    localparam int XH  = 1;
    localparam int YL  = 2;
    localparam int YH  = 3;
    localparam int BTN = 4;

    typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT} state_t;

    // Byte 0 lands in the top bits so the frame shifts out MSB first.
    function automatic logic [39:0] build_frame(input logic [9:0] x, input logic [9:0] y,
                                                input logic [7:0] btn);
        logic [0:4][7:0] b;
        b[XL]  = x[7:0];
        b[XH]  = {6'b0, x[9:8]};
        b[YL]  = y[7:0];
        b[YH]  = {6'b0, y[9:8]};
        b[BTN] = btn;
        return b;
    endfunction

endpackage

// File: rtl/jstk2_spi_responder_sync.sv
// sync_edge_detect: multi-flop synchroniser with one-cycle rise/fall pulses on the synchronised level.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sh;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            prev <= 1'b0;
        end else begin
            sh   <= {sh[STAGES-2:0], d};
            prev <= sh[STAGES-1];
        end
    end

    assign level = sh[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/jstk2_spi_responder.sv
// jstk2_spi_responder: SPI mode-0 target emulating a JSTK2 joystick, oversampled in the CLK domain.
// Define JSTK2_LED_CMD_EN to add the led_rgb port driven by the 0x84 set-LED command.
module jstk2_spi_responder
    import jstk2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SCK,
    input  logic        CS_n,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [9:0]  x_val,
    input  logic [9:0]  y_val,
    input  logic [7:0]  btn_val,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  rx_cmd
`ifdef JSTK2_LED_CMD_EN
    ,
    output logic [23:0] led_rgb
`endif
);

    localparam int BW = $clog2(FRAME_BYTES + 1);
`ifdef JSTK2_LED_CMD_EN
    localparam int RXN = 4;
`else
    localparam int RXN = 1;
`endif

    logic sck_rise, sck_fall, cs_lvl, cs_rise, cs_fall, mosi_lvl;
    logic unused_sck_lvl, unused_mosi_rise, unused_mosi_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sck (
        .clk(CLK), .rst(RST), .d(SCK),
        .level(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_cs (
        .clk(CLK), .rst(RST), .d(CS_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_mosi (
        .clk(CLK), .rst(RST), .d(MOSI),
        .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    state_t         state, state_nx;
    logic [39:0]    frame, tx_sh;
    logic [2:0]     bit_cnt;
    logic [BW-1:0]  byte_cnt;
    logic [6:0]     rx_sh;
    logic [7:0]     rx_buf [RXN];
    logic           load, close, sck_in, sck_out, done_nx, err_nx, full;

    assign frame = build_frame(x_val, y_val, btn_val);
    assign full  = byte_cnt >= BW'(FRAME_BYTES);

    // A CS_n edge pre-empts any SCK edge seen in the same cycle.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        close    = 1'b0;
        sck_in   = 1'b0;
        sck_out  = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            WAIT_HI: state_nx = cs_lvl ? IDLE : WAIT_HI;
            IDLE: begin
                load     = cs_fall;
                state_nx = cs_fall ? SHIFT : IDLE;
            end
            SHIFT: begin
                close    = cs_rise;
                state_nx = cs_rise ? IDLE : SHIFT;
                done_nx  = cs_rise && bit_cnt == 3'd0 && byte_cnt == BW'(FRAME_BYTES);
                err_nx   = cs_rise && !done_nx;
                sck_in   = !cs_rise && sck_rise;
                sck_out  = !cs_rise && sck_fall;
            end
            default: state_nx = WAIT_HI;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= WAIT_HI;
            MISO       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rx_cmd     <= 8'h00;
            tx_sh      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            rx_sh      <= '0;
        end else begin
            state      <= state_nx;
            frame_done <= done_nx;
            frame_err  <= err_nx;
            if (load) begin
                MISO  <= frame[39];
                tx_sh <= {frame[38:0], 1'b0};
            end
            if (close) begin
                MISO     <= 1'b0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end
            if (done_nx)
                rx_cmd <= rx_buf[0];
            if (sck_in) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (!full)
                    rx_sh <= {rx_sh[5:0], mosi_lvl};
                if (!full && bit_cnt == 3'd7)
                    byte_cnt <= byte_cnt + BW'(1);
            end
            if (sck_out) begin
                MISO  <= tx_sh[39] & !full;
                tx_sh <= {tx_sh[38:0], 1'b0};
            end
        end
    end

    for (genvar i = 0; i < RXN; i++) begin : g_rx
        always_ff @(posedge CLK)
            if (sck_in && bit_cnt == 3'd7 && byte_cnt == BW'(i))
                rx_buf[i] <= {rx_sh, mosi_lvl};
    end

`ifdef JSTK2_LED_CMD_EN
    always_ff @(posedge CLK) begin
        if (RST)
            led_rgb <= 24'h0;
        else if (done_nx && rx_buf[0] == JSTK2_CMD_SET_LED)
            led_rgb <= {rx_buf[1], rx_buf[2], rx_buf[3]};
    end
`endif

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// tb_jstk2_spi_responder: randomized SPI initiator checked against a byte-level frame model.
module tb_jstk2_spi_responder;

    logic       CLK = 1'b0, RST = 1'b1, SCK = 1'b0, CS_n = 1'b1, MOSI = 1'b0;
    logic       MISO, frame_done, frame_err;
    logic [9:0] x_val, y_val;
    logic [7:0] btn_val, rx_cmd;
`ifdef JSTK2_LED_CMD_EN
    logic [23:0] led_rgb;
    logic [23:0] led_m = 24'h0;
`endif

    int         checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
    logic [7:0] mosi_b [8];
    logic [7:0] cmd_m = 8'h00;
    logic       seen;
    int         d0, e0;

    jstk2_spi_responder dut (
        .CLK(CLK), .RST(RST), .SCK(SCK), .CS_n(CS_n), .MOSI(MOSI), .MISO(MISO),
        .x_val(x_val), .y_val(y_val), .btn_val(btn_val),
        .frame_done(frame_done), .frame_err(frame_err), .rx_cmd(rx_cmd)
`ifdef JSTK2_LED_CMD_EN
        , .led_rgb(led_rgb)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic sck_pulses(input int n, output logic any);
        any = 1'b0;
        repeat (n) begin
            tick(8); SCK = 1'b1; any |= MISO;
            tick(8); SCK = 1'b0; any |= MISO;
        end
    endtask

    task automatic rand_mosi();
        for (int k = 0; k < 8; k++) mosi_b[k] = 8'($urandom);
        if ($urandom_range(0, 1) == 0) mosi_b[0] = 8'h84;
    endtask

    // nb whole bytes plus xb extra bits; x_val switches to nx at the start of byte chg.
    task automatic run_frame(input int nb, input int xb, input int chg, input logic [9:0] nx);
        logic [7:0] exp_b [8];
        logic [7:0] rd;
        int         fd, fe;
        logic       ok;
        for (int k = 0; k < 8; k++) exp_b[k] = 8'h00;
        exp_b[0] = 8'(x_val % 10'd256);
        exp_b[1] = 8'(x_val / 10'd256);
        exp_b[2] = 8'(y_val % 10'd256);
        exp_b[3] = 8'(y_val / 10'd256);
        exp_b[4] = btn_val;
        fd = done_cnt; fe = err_cnt; rd = 8'h00;
        CS_n = 1'b0;
        tick(8);
        for (int i = 0; i < nb * 8 + xb; i++) begin
            if (i % 8 == 0 && i / 8 == chg) x_val = nx;
            MOSI = mosi_b[i / 8][7 - i % 8];
            tick(8); SCK = 1'b1;
            rd = {rd[6:0], MISO};
            if (i % 8 == 7) check($sformatf("byte%0d", i / 8), 32'(rd), 32'(exp_b[i / 8]));
            tick(8); SCK = 1'b0;
        end
        tick(8); CS_n = 1'b1;
        tick(10);
        check("miso_idle", 32'(MISO), 32'd0);
        ok = xb == 0 && nb >= 5;
        check("done_pulses", done_cnt - fd, 32'(ok));
        check("err_pulses", err_cnt - fe, 32'(!ok));
        if (ok) begin
            cmd_m = mosi_b[0];
`ifdef JSTK2_LED_CMD_EN
            if (mosi_b[0] == 8'h84) led_m = {mosi_b[1], mosi_b[2], mosi_b[3]};
`endif
        end
        check("rx_cmd", 32'(rx_cmd), 32'(cmd_m));
`ifdef JSTK2_LED_CMD_EN
        check("led_rgb", 32'(led_rgb), 32'(led_m));
`endif
    endtask

    initial begin
        x_val = 10'd830; y_val = 10'd228; btn_val = 8'h01;
        for (int k = 0; k < 8; k++) mosi_b[k] = 8'h00;
        tick(4);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_rx_cmd", 32'(rx_cmd), 32'd0);
`ifdef JSTK2_LED_CMD_EN
        check("rst_led", 32'(led_rgb), 32'd0);
`endif
        RST = 1'b0;
        tick(8);

        rand_mosi();
        run_frame(5, 0, -1, 10'd0);

        mosi_b[0] = 8'h84; mosi_b[1] = 8'hFF; mosi_b[2] = 8'h00; mosi_b[3] = 8'h80; mosi_b[4] = 8'h00;
        run_frame(5, 0, -1, 10'd0);

        rand_mosi(); mosi_b[0] = 8'h84;
        run_frame(2, 3, -1, 10'd0);

        x_val = 10'd100;
        run_frame(5, 0, 1, 10'd900);
        run_frame(5, 0, -1, 10'd0);

        rand_mosi();
        run_frame(7, 0, -1, 10'd0);

        d0 = done_cnt; e0 = err_cnt;
        CS_n = 1'b0;
        tick(8);
        sck_pulses(12, seen);
        RST = 1'b1; tick(2); RST = 1'b0; tick(2);
        check("rst_mid_miso", 32'(MISO), 32'd0);
        sck_pulses(10, seen);
        check("rst_mid_miso_hold", 32'(seen), 32'd0);
        CS_n = 1'b1;
        tick(10);
        check("rst_mid_done", done_cnt - d0, 32'd0);
        check("rst_mid_err", err_cnt - e0, 32'd0);
        cmd_m = 8'h00;
`ifdef JSTK2_LED_CMD_EN
        led_m = 24'h0;
`endif
        rand_mosi();
        run_frame(5, 0, -1, 10'd0);

        d0 = done_cnt; e0 = err_cnt;
        sck_pulses(16, seen);
        tick(10);
        check("cs_hi_miso", 32'(seen), 32'd0);
        check("cs_hi_done", done_cnt - d0, 32'd0);
        check("cs_hi_err", err_cnt - e0, 32'd0);

        for (int n = 0; n < 24; n++) begin
            int nb, xb, chg;
            x_val   = 10'($urandom_range(0, 1023));
            y_val   = 10'($urandom_range(0, 1023));
            btn_val = 8'($urandom);
            rand_mosi();
            nb  = $urandom_range(3, 7);
            xb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            chg = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
            run_frame(nb, xb, chg, 10'($urandom_range(0, 1023)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
